and_edge_counter: RTL

//  Downstream consumer of the registered AND stage output (and_out).

---
 rtl/and_edge_pkg.sv | 20 ++
 rtl/and_edge_counter_edge_detect.sv | 36 +++
 rtl/and_edge_counter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/and_edge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : and_edge_pkg
//  Description : Shared types and default constants for and_edge_counter.
//  Revision    : 1.0  initial release
// ============================================================================
package and_edge_pkg;

  // Window controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } edge_state_t;

  localparam int CNT_W_DEF      = 8;
  localparam int WINDOW_LEN_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/and_edge_counter_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : One-flop history of din with combinational rise/fall strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  // Previous level simply follows the input every clock
  always_comb begin
    prev_d = din;
  end

  // History flop; cleared to 0 so a level held high through reset reads as a rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

endmodule
`default_nettype wire

// File: rtl/and_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : and_edge_counter
//  Description : Counts edges of and_in over a WINDOW_LEN-clock window after
//                start, then holds a saturating count under valid/ready.
//                Macro AND_EDGE_BOTH_EN: count rising and falling edges
//                (default: rising edges only).
//  Revision    : 1.0  initial release
// ============================================================================
module and_edge_counter
  import and_edge_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WINDOW_LEN = WINDOW_LEN_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             and_in,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat
);

  localparam int               WIN_W    = $clog2(WINDOW_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

  edge_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_sat_q, res_sat_d;

  logic rise;
  logic fall;
  logic edge_ev;

  edge_detect u_edge_detect (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (and_in),
    .rise    (rise),
    .fall    (fall)
  );

`ifdef AND_EDGE_BOTH_EN
  assign edge_ev = rise | fall;
`else
  logic unused_fall;
  assign unused_fall = fall;
  assign edge_ev     = rise;
`endif

  // Next-state and counter logic for the IDLE -> COUNT -> HOLD window cycle
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    win_d       = win_q;
    sat_d       = sat_q;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          count_d = '0;
          win_d   = '0;
          sat_d   = 1'b0;
        end
      end
      COUNT: begin
        win_d = win_q + 1'b1;
        if (edge_ev) begin
          if (count_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        // Last sample includes its own edge in the published result
        if (win_q == WIN_LAST) begin
          state_d     = HOLD;
          res_count_d = count_d;
          res_sat_d   = sat_d;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and result registers; reset aborts any window in progress
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      win_q       <= '0;
      sat_q       <= 1'b0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      win_q       <= win_d;
      sat_q       <= sat_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == HOLD);
  assign res_count = res_count_q;
  assign res_sat   = res_sat_q;

endmodule
`default_nettype wire
